// File: rtl/acl2_pkg.sv
// Shared constants and state encoding for the ADXL362 (Pmod ACL2) sample sequencer.
// Optional STATUS polling is compiled in with ACL2_SEQ_STATUS_EN.
package acl2_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [7:0] POWER_CTL = 8'h2D;
  localparam logic [7:0] STATUS    = 8'h0B;
  localparam logic [7:0] XDATA     = 8'h08;
  localparam logic [7:0] YDATA     = 8'h09;
  localparam logic [7:0] ZDATA     = 8'h0A;

  localparam logic [7:0] POWER_CTL_MEASURE = 8'h02;

  typedef enum logic [3:0] {
    PWRUP_WAIT,
    CFG_REQ,
    CFG_WAIT,
    IDLE,
`ifdef ACL2_SEQ_STATUS_EN
    STAT_REQ,
    STAT_WAIT,
`endif
    AXIS_REQ,
    AXIS_WAIT,
    PUBLISH,
    FAULT
  } acl2_state_e;

  function automatic logic [7:0] axis_addr(input logic [1:0] axis);
    case (axis)
      2'd0:    axis_addr = XDATA;
      2'd1:    axis_addr = YDATA;
      default: axis_addr = ZDATA;
    endcase
  endfunction

endpackage

// File: rtl/acl2_tick_gen.sv
// Reloading down-counter: while run is high, tick pulses once every LOAD cycles,
// the first pulse landing on the LOAD-th running cycle.
module acl2_tick_gen #(
  parameter int unsigned LOAD = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (LOAD > 1) ? $clog2(LOAD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(LOAD - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST || !run || cnt_q == '0) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = run && (cnt_q == '0);

endmodule

// File: rtl/acl2_sample_sequencer.sv
// Drives the ADXL362 SPI byte engine: power-up wait, POWER_CTL write, then periodic
// X/Y/Z reads published as one coherent triple. ACL2_SEQ_STATUS_EN adds DATA_READY polling.
module acl2_sample_sequencer
  import acl2_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES   = 625000,
  parameter int unsigned SAMPLE_DIV     = 1250000,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  output logic       SPI_START,
  output logic [7:0] SPI_CMD,
  output logic [7:0] SPI_ADDR,
  output logic [7:0] SPI_WDATA,
  input  logic       SPI_BUSY,
  input  logic       SPI_DONE,
  input  logic [7:0] SPI_RDATA,
  output logic [7:0] X_DATA,
  output logic [7:0] Y_DATA,
  output logic [7:0] Z_DATA,
  output logic       SAMPLE_VALID,
  output logic       CFG_DONE,
  output logic       ERROR
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  acl2_state_e     state_q, state_d;
  logic [1:0]      axis_q, axis_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            start_q, start_d;
  logic [7:0]      cmd_q, cmd_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]      x_q, x_d, y_q, y_d, z_q, z_d;
  logic            valid_q, valid_d;
  logic            cfg_done_q, cfg_done_d;
  logic            error_q, error_d;
  logic [7:0]      sh_x_q, sh_y_q;
  logic            pwrup_run, pwrup_tick, sample_tick, to_expired, go_fault;
`ifdef ACL2_SEQ_STATUS_EN
  logic            stat_rpt_q, stat_rpt_d;
`endif

  assign pwrup_run  = (state_q == PWRUP_WAIT);
  assign to_expired = (to_cnt_q == TO_LAST);

  acl2_tick_gen #(.LOAD(PWRUP_CYCLES)) u_pwrup_tick (
    .CLK  (CLK),
    .RST  (RST),
    .run  (pwrup_run),
    .tick (pwrup_tick)
  );

  acl2_tick_gen #(.LOAD(SAMPLE_DIV)) u_sample_tick (
    .CLK  (CLK),
    .RST  (RST),
    .run  (cfg_done_q),
    .tick (sample_tick)
  );

  always_comb begin
    state_d    = state_q;
    axis_d     = axis_q;
    to_cnt_d   = to_cnt_q;
    start_d    = 1'b0;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    valid_d    = 1'b0;
    cfg_done_d = cfg_done_q;
    error_d    = error_q;
    go_fault   = 1'b0;
`ifdef ACL2_SEQ_STATUS_EN
    stat_rpt_d = stat_rpt_q;
`endif

    case (state_q)
      PWRUP_WAIT: if (pwrup_tick) state_d = CFG_REQ;

      CFG_REQ: if (!SPI_BUSY) begin
        start_d  = 1'b1;
        cmd_d    = CMD_WRITE;
        addr_d   = POWER_CTL;
        wdata_d  = POWER_CTL_MEASURE;
        to_cnt_d = '0;
        state_d  = CFG_WAIT;
      end

      CFG_WAIT: begin
        if (SPI_DONE) begin
          cfg_done_d = 1'b1;
          state_d    = IDLE;
        end else if (to_expired) go_fault = 1'b1;
        else to_cnt_d = to_cnt_q + 1'b1;
      end

      // Ticks arriving in any other state are dropped, never queued.
      IDLE: if (sample_tick && ENABLE) begin
        axis_d   = 2'd0;
        to_cnt_d = '0;
`ifdef ACL2_SEQ_STATUS_EN
        stat_rpt_d = 1'b0;
        state_d    = STAT_REQ;
`else
        state_d    = AXIS_REQ;
`endif
      end

`ifdef ACL2_SEQ_STATUS_EN
      // The poll timeout spans every repeat, so the count only restarts on leaving IDLE.
      STAT_REQ: begin
        if (stat_rpt_q) begin
          if (to_expired) go_fault = 1'b1;
          else to_cnt_d = to_cnt_q + 1'b1;
        end
        if (!SPI_BUSY && !go_fault) begin
          start_d = 1'b1;
          cmd_d   = CMD_READ;
          addr_d  = STATUS;
          wdata_d = 8'h00;
          state_d = STAT_WAIT;
        end
      end

      STAT_WAIT: begin
        if (SPI_DONE && SPI_RDATA[0]) begin
          axis_d   = 2'd0;
          to_cnt_d = '0;
          if (!SPI_BUSY) begin
            start_d = 1'b1;
            cmd_d   = CMD_READ;
            addr_d  = XDATA;
            state_d = AXIS_WAIT;
          end else state_d = AXIS_REQ;
        end else if (to_expired) go_fault = 1'b1;
        else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (SPI_DONE) begin
            stat_rpt_d = 1'b1;
            if (!SPI_BUSY) start_d = 1'b1;
            else state_d = STAT_REQ;
          end
        end
      end
`endif

      AXIS_REQ: if (!SPI_BUSY) begin
        start_d  = 1'b1;
        cmd_d    = CMD_READ;
        addr_d   = axis_addr(axis_q);
        wdata_d  = 8'h00;
        to_cnt_d = '0;
        state_d  = AXIS_WAIT;
      end

      // Z bypasses its shadow so the triple is published the cycle after its DONE.
      AXIS_WAIT: begin
        if (SPI_DONE) begin
          to_cnt_d = '0;
          if (axis_q == 2'd2) begin
            x_d     = sh_x_q;
            y_d     = sh_y_q;
            z_d     = SPI_RDATA;
            valid_d = 1'b1;
            state_d = PUBLISH;
          end else begin
            axis_d = axis_q + 2'd1;
            if (!SPI_BUSY) begin
              start_d = 1'b1;
              addr_d  = axis_addr(axis_q + 2'd1);
            end else state_d = AXIS_REQ;
          end
        end else if (to_expired) go_fault = 1'b1;
        else to_cnt_d = to_cnt_q + 1'b1;
      end

      PUBLISH: state_d = IDLE;

      FAULT: state_d = FAULT;

      default: state_d = FAULT;
    endcase

    if (go_fault) begin
      state_d = FAULT;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= PWRUP_WAIT;
      axis_q     <= 2'd0;
      to_cnt_q   <= '0;
      start_q    <= 1'b0;
      cmd_q      <= 8'h00;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      x_q        <= 8'h00;
      y_q        <= 8'h00;
      z_q        <= 8'h00;
      valid_q    <= 1'b0;
      cfg_done_q <= 1'b0;
      error_q    <= 1'b0;
`ifdef ACL2_SEQ_STATUS_EN
      stat_rpt_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      axis_q     <= axis_d;
      to_cnt_q   <= to_cnt_d;
      start_q    <= start_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      valid_q    <= valid_d;
      cfg_done_q <= cfg_done_d;
      error_q    <= error_d;
`ifdef ACL2_SEQ_STATUS_EN
      stat_rpt_q <= stat_rpt_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == AXIS_WAIT && SPI_DONE) begin
      case (axis_q)
        2'd0:    sh_x_q <= SPI_RDATA;
        2'd1:    sh_y_q <= SPI_RDATA;
        default: ;
      endcase
    end
  end

  assign SPI_START    = start_q;
  assign SPI_CMD      = cmd_q;
  assign SPI_ADDR     = addr_q;
  assign SPI_WDATA    = wdata_q;
  assign X_DATA       = x_q;
  assign Y_DATA       = y_q;
  assign Z_DATA       = z_q;
  assign SAMPLE_VALID = valid_q;
  assign CFG_DONE     = cfg_done_q;
  assign ERROR        = error_q;

endmodule

// File: tb/tb_acl2_sample_sequencer.sv
// Scoreboard bench for acl2_sample_sequencer with a behavioural SPI engine model.
// Build with ACL2_SEQ_STATUS_EN to exercise the STATUS polling variant.
module tb_acl2_sample_sequencer;

  localparam int P   = 50;
  localparam int DIV = 400;
  localparam int TO  = 200;
  localparam int LAT = 40;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] wdata;
    bit         first;
  } txn_t;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
  } smp_t;

  logic       CLK, RST, ENABLE;
  logic       SPI_START, SPI_DONE;
  logic [7:0] SPI_CMD, SPI_ADDR, SPI_WDATA, SPI_RDATA;
  logic [7:0] X_DATA, Y_DATA, Z_DATA;
  logic       SAMPLE_VALID, CFG_DONE, ERROR;
  logic       m_busy, hold_busy, hold_next, hang, spi_busy;

  assign spi_busy = m_busy | hold_busy;

  txn_t       exp_txn[$];
  smp_t       exp_smp[$];
  logic [7:0] rd_q[$];
  logic [7:0] stat_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int start_cnt = 0, valid_cnt = 0, last_start_cyc = 0;
  int done_cyc = 0, z_done_cyc = 0, first_cyc = 0;
  bit have_first = 0, hold_seen = 0;
  logic [7:0] cur_cmd, cur_addr, cur_wdata;
  logic [23:0] prev_xyz;

  acl2_sample_sequencer #(
    .PWRUP_CYCLES(P), .SAMPLE_DIV(DIV), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
    .SPI_START(SPI_START), .SPI_CMD(SPI_CMD), .SPI_ADDR(SPI_ADDR), .SPI_WDATA(SPI_WDATA),
    .SPI_BUSY(spi_busy), .SPI_DONE(SPI_DONE), .SPI_RDATA(SPI_RDATA),
    .X_DATA(X_DATA), .Y_DATA(Y_DATA), .Z_DATA(Z_DATA),
    .SAMPLE_VALID(SAMPLE_VALID), .CFG_DONE(CFG_DONE), .ERROR(ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SPI engine model: BUSY from START until DONE, DONE LAT cycles after START.
  initial begin
    logic [7:0] a;
    m_busy = 1'b0; hold_busy = 1'b0; SPI_DONE = 1'b0; SPI_RDATA = 8'h00;
    forever begin
      @(posedge CLK); #1;
      SPI_DONE = 1'b0;
      if (RST) m_busy = 1'b0;
      else if (SPI_START) begin
        m_busy = 1'b1;
        if (!hang) begin
          a = SPI_ADDR;
          repeat (LAT - 1) @(posedge CLK);
          #1;
          if (SPI_CMD == 8'h0B && a == 8'h0B) SPI_RDATA = (stat_q.size() > 0) ? stat_q.pop_front() : 8'h01;
          else if (SPI_CMD == 8'h0B) SPI_RDATA = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
          else SPI_RDATA = 8'h00;
          SPI_DONE = 1'b1;
          m_busy   = 1'b0;
          done_cyc = cyc;
          if (a == 8'h0A) z_done_cyc = cyc;
          if (hold_next && a == 8'h08) begin hold_busy = 1'b1; hold_next = 1'b0; end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a transaction or publishes a sample.
  always @(negedge CLK) begin
    txn_t t;
    smp_t s;
    if (RST) begin
      have_first = 0; hold_seen = 0;
      prev_xyz = {X_DATA, Y_DATA, Z_DATA};
    end else begin
      if (hold_busy) hold_seen = 1;
      if (SPI_START) begin
        start_cnt++;
        last_start_cyc = cyc;
        if (exp_txn.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: cmd 0x%0h addr 0x%0h, none expected (cycle %0d)", SPI_CMD, SPI_ADDR, cyc);
        end else begin
          t = exp_txn.pop_front();
          chk("txn_cmd", {24'd0, SPI_CMD}, {24'd0, t.cmd});
          chk("txn_addr", {24'd0, SPI_ADDR}, {24'd0, t.addr});
          if (t.cmd == 8'h0A) chk("txn_wdata", {24'd0, SPI_WDATA}, {24'd0, t.wdata});
          if (t.first) begin
            if (have_first) chk("sample_start_on_wrap", (cyc - first_cyc) % DIV, 0);
            have_first = 1; first_cyc = cyc;
          end else if (t.cmd == 8'h0B && !hold_seen) chk("done_to_next_start", cyc, done_cyc + 1);
        end
        hold_seen = 0;
        cur_cmd = SPI_CMD; cur_addr = SPI_ADDR; cur_wdata = SPI_WDATA;
      end else if (spi_busy) begin
        chk("cmd_stable", {8'd0, SPI_CMD, SPI_ADDR, SPI_WDATA}, {8'd0, cur_cmd, cur_addr, cur_wdata});
      end
      if (SAMPLE_VALID) begin
        valid_cnt++;
        if (exp_smp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: xyz 0x%0h, none expected (cycle %0d)", {X_DATA, Y_DATA, Z_DATA}, cyc);
        end else begin
          s = exp_smp.pop_front();
          chk("sample_xyz", {8'd0, X_DATA, Y_DATA, Z_DATA}, {8'd0, s.x, s.y, s.z});
          chk("valid_after_zdone", cyc, z_done_cyc + 1);
        end
      end else begin
        chk("xyz_hold_without_valid", {8'd0, X_DATA, Y_DATA, Z_DATA}, {8'd0, prev_xyz});
      end
      prev_xyz = {X_DATA, Y_DATA, Z_DATA};
    end
  end

  // Reference: a sample is optional STATUS polling then reads of 0x08, 0x09, 0x0A.
  task automatic plan(input logic [7:0] x, y, z, input int nwait, input logic [7:0] st_mask);
    bit fx;
    fx = 1'b1;
    for (int i = 0; i <= nwait; i++) begin
      if (i == nwait) stat_q.push_back((8'($urandom_range(0, 255)) & st_mask) | 8'h01);
      else stat_q.push_back(8'($urandom_range(0, 255)) & st_mask & 8'hFE);
`ifdef ACL2_SEQ_STATUS_EN
      exp_txn.push_back('{8'h0B, 8'h0B, 8'h00, (i == 0)});
      fx = 1'b0;
`endif
    end
`ifndef ACL2_SEQ_STATUS_EN
    stat_q.delete();
`endif
    exp_txn.push_back('{8'h0B, 8'h08, 8'h00, fx});
    exp_txn.push_back('{8'h0B, 8'h09, 8'h00, 1'b0});
    exp_txn.push_back('{8'h0B, 8'h0A, 8'h00, 1'b0});
    rd_q.push_back(x); rd_q.push_back(y); rd_q.push_back(z);
    exp_smp.push_back('{x, y, z});
  endtask

  task automatic plan_random(input int nwait);
    plan(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), nwait, 8'hFF);
  endtask

  task automatic wait_valid(input int target, input int budget);
    int n;
    n = 0;
    while (valid_cnt < target && n < budget) begin @(posedge CLK); #2; n++; end
    chk("sample_published", valid_cnt, target);
    chk("error_low", {31'd0, ERROR}, 32'd0);
  endtask

  task automatic power_up();
    int n;
    bit seen;
    exp_txn.push_back('{8'h0A, 8'h2D, 8'h02, 1'b0});
    @(posedge CLK); #1;
    RST = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < P + 20) begin
      @(posedge CLK); #1; n++;
      if (SPI_START) seen = 1;
    end
    chk("first_start_latency", n, P + 1);
    chk("cfg_done_before_write", {31'd0, CFG_DONE}, 32'd0);
    n = 0;
    while (!CFG_DONE && n < LAT + 20) begin @(posedge CLK); #1; n++; end
    chk("cfg_done", {31'd0, CFG_DONE}, 32'd1);
  endtask

  initial begin
    int n, s0, v0, ts, te;
    RST = 1'b1; ENABLE = 1'b1; hang = 1'b0; hold_next = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_start", {31'd0, SPI_START}, 32'd0);
    chk("rst_cmd_addr_wdata", {8'd0, SPI_CMD, SPI_ADDR, SPI_WDATA}, 32'd0);
    chk("rst_xyz", {8'd0, X_DATA, Y_DATA, Z_DATA}, 32'd0);
    chk("rst_flags", {29'd0, SAMPLE_VALID, CFG_DONE, ERROR}, 32'd0);

    power_up();

    plan(8'h12, 8'hF0, 8'h7F, 2, 8'h00);
    wait_valid(1, DIV + 400);

    // Engine stays busy at the Y request for 100 cycles.
    hold_next = 1'b1;
    plan_random(0);
    n = 0;
    while (!hold_busy && n < DIV + 300) begin @(posedge CLK); #1; n++; end
    chk("hold_reached", {31'd0, hold_busy}, 32'd1);
    s0 = start_cnt;
    repeat (100) @(posedge CLK);
    #1;
    chk("no_start_while_busy", start_cnt, s0);
    chk("cmd_addr_held", {16'd0, SPI_CMD, SPI_ADDR}, {16'd0, 8'h0B, 8'h08});
    hold_busy = 1'b0;
    n = 0;
    while (start_cnt == s0 && n < 5) begin @(posedge CLK); #2; n++; end
    chk("start_after_busy_falls", start_cnt, s0 + 1);
    wait_valid(2, DIV + 300);

    for (int i = 0; i < 4; i++) begin
      plan_random($urandom_range(0, 2));
      wait_valid(3 + i, DIV + 400);
    end

    // Two whole periods with sampling disabled.
    ENABLE = 1'b0;
    s0 = start_cnt; v0 = valid_cnt;
    repeat (2 * DIV + DIV / 2) @(posedge CLK);
    #2;
    chk("disabled_no_reads", start_cnt, s0);
    chk("disabled_no_valid", valid_cnt, v0);
    plan_random(1);
    ENABLE = 1'b1;
    wait_valid(v0 + 1, DIV + 400);

    // Engine never completes.
    hang = 1'b1;
`ifdef ACL2_SEQ_STATUS_EN
    exp_txn.push_back('{8'h0B, 8'h0B, 8'h00, 1'b1});
`else
    exp_txn.push_back('{8'h0B, 8'h08, 8'h00, 1'b1});
`endif
    s0 = start_cnt; n = 0;
    while (start_cnt == s0 && n < DIV + 100) begin @(posedge CLK); #2; n++; end
    chk("hang_start_issued", start_cnt, s0 + 1);
    ts = last_start_cyc;
    n = 0;
    while (!ERROR && n < TO + 50) begin @(negedge CLK); n++; end
    te = cyc;
    chk("error_set", {31'd0, ERROR}, 32'd1);
    chk("timeout_window", ((te - ts) >= TO && (te - ts) <= TO + 2) ? 32'd1 : 32'd0, 32'd1);
    s0 = start_cnt;
    repeat (3 * DIV) @(posedge CLK);
    #2;
    chk("fault_no_start", start_cnt, s0);
    chk("error_sticky", {31'd0, ERROR}, 32'd1);

    RST = 1'b1;
    hang = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_clears_error", {30'd0, CFG_DONE, ERROR}, 32'd0);
    chk("rst_clears_xyz", {8'd0, X_DATA, Y_DATA, Z_DATA}, 32'd0);
    v0 = valid_cnt;
    power_up();
    plan_random(0);
    wait_valid(v0 + 1, DIV + 400);

    chk("txn_queue_drained", exp_txn.size(), 0);
    chk("sample_queue_drained", exp_smp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acl2_sample_sequencer.md
# acl2_sample_sequencer

Sequencer that owns the ADXL362 (Pmod ACL2) SPI byte-transaction engine and autonomously runs the accelerometer. After power-up it writes the measurement-mode configuration, then reads XDATA/YDATA/ZDATA at a fixed sample rate. It publishes one coherent X/Y/Z triple per sample. It sits between the SPI master (CS/SCLK/MOSI/MISO side) and the user logic that consumes acceleration samples.

## Interface
- PWRUP_CYCLES, 625000: CLK cycles to wait after reset before the first transaction (5 ms at 125 MHz).
- SAMPLE_DIV, 1250000: CLK cycles per sample period (100 Hz at 125 MHz); must be ≥ 2.
- TIMEOUT_CYCLES, 65535: maximum CLK cycles from SPI_START to SPI_DONE before an error is declared.
- CLK  input  1  125 MHz system clock.
- RST  input  1  synchronous, active-high reset.
- ENABLE  input  1  when low, no new sample period is started.
- SPI_START  output  1  one-cycle transaction request to the SPI engine.
- SPI_CMD  output  8  instruction byte: 0x0A write, 0x0B register read.
- SPI_ADDR  output  8  register address.
- SPI_WDATA  output  8  write data byte.
- SPI_BUSY  input  1  engine is mid-transaction.
- SPI_DONE  input  1  one-cycle completion pulse; SPI_RDATA is valid in the same cycle.
- SPI_RDATA  input  8  read byte.
- X_DATA, Y_DATA, Z_DATA  output  8 each  last published sample, two's complement.
- SAMPLE_VALID  output  1  one-cycle pulse when X/Y/Z update.
- CFG_DONE  output  1  high once configuration has completed.
- ERROR  output  1  sticky timeout flag; cleared only by RST.

## Operation
- States: PWRUP_WAIT, CFG_REQ, CFG_WAIT, IDLE, [STAT_REQ, STAT_WAIT], AXIS_REQ, AXIS_WAIT, PUBLISH, FAULT.
- PWRUP_WAIT: count PWRUP_CYCLES, then go to CFG_REQ.
- CFG_REQ: issue CMD=0x0A, ADDR=0x2D (POWER_CTL), WDATA=0x02. CFG_WAIT waits for SPI_DONE, then sets CFG_DONE and goes to IDLE.
- IDLE: the sample timer runs continuously from CFG_DONE and wraps every SAMPLE_DIV cycles. On wrap with ENABLE=1, start a sample. A wrap with ENABLE=0 is skipped.
- A sample is three reads with CMD=0x0B and ADDR 0x08, 0x09, 0x0A, in that order. An internal axis index (0..2) selects the address and the shadow register that captures SPI_RDATA on SPI_DONE.
- PUBLISH: copy all three shadow registers to X/Y/Z_DATA in one cycle and pulse SAMPLE_VALID. Outputs never show a partially updated triple.
- SPI_START is asserted only when SPI_BUSY=0. While the engine is busy, the REQ state holds.
- SPI_CMD, SPI_ADDR and SPI_WDATA are stable from SPI_START until SPI_DONE.
- If a timer wrap occurs while a sample is in progress, it is dropped. Sample requests are not queued.
- If any WAIT state exceeds TIMEOUT_CYCLES, go to FAULT and set ERROR. FAULT stays there until RST. No further SPI_START is issued.
- Spurious SPI_DONE outside a WAIT state is ignored.
- RST mid-transaction returns to PWRUP_WAIT. The SPI engine shares RST and aborts its transaction with CS released.

## Timing
- Reset values: SPI_START=0, SPI_CMD/SPI_ADDR/SPI_WDATA=0, X/Y/Z_DATA=0, SAMPLE_VALID=0, CFG_DONE=0, ERROR=0, state=PWRUP_WAIT.
- All outputs are registered.
- The first SPI_START is asserted PWRUP_CYCLES+1 cycles after RST deasserts (for SPI_BUSY=0).
- SPI_DONE in cycle N causes SPI_START for the next read in cycle N+1.
- The SPI_DONE of the Z read in cycle N causes SAMPLE_VALID in cycle N+1.
- The timeout counter starts at SPI_START and resets on SPI_DONE.

## Configuration
- ACL2_SEQ_STATUS_EN defined: each sample first reads STATUS (CMD=0x0B, ADDR=0x0B).
  - If bit0 (DATA_READY)=1, the X/Y/Z reads follow.
  - Otherwise the status read repeats, one per SPI_DONE, until ready or timeout. The timeout here counts from the first status SPI_START.
- Undefined: the STAT states are absent and the X read starts directly from IDLE.

## Structure
- Package acl2_pkg holds:
  - instruction constants: CMD_WRITE=0x0A, CMD_READ=0x0B.
  - register addresses: POWER_CTL=0x2D, STATUS=0x0B, XDATA=0x08, YDATA=0x09, ZDATA=0x0A.
  - the POWER_CTL measurement value 0x02.
  - the state enum.
- One sub-module, acl2_tick_gen: a parameterised down-counter producing the PWRUP done and periodic sample-tick pulses.

## Test plan
- Reset, with an SPI model that completes in 40 cycles -> after PWRUP_CYCLES, exactly one write of 0x2D←0x02, then CFG_DONE=1.
- Model returns 0x12, 0xF0, 0x7F for the three reads -> SAMPLE_VALID pulses once. X/Y/Z = 0x12, 0xF0, 0x7F, all changing in the same cycle.
- Hold SPI_BUSY=1 for 100 cycles at a request -> SPI_START stays low until BUSY falls, and command/address are unchanged.
- Model never returns SPI_DONE -> ERROR=1 after TIMEOUT_CYCLES. No further SPI_START until RST, after which power-up is repeated.
- ENABLE=0 across two periods -> no reads and no SAMPLE_VALID. Raising ENABLE resumes sampling at the next wrap.
- With ACL2_SEQ_STATUS_EN, STATUS returns 0x00, 0x00, 0x01 -> three status reads, then the X/Y/Z reads and one SAMPLE_VALID.
